neuron_acc_ctrl: RTL and testbench

Sequencing and sign-magnitude control stage that sits directly upstream of the neuron accumulator adder. It consumes a stream of signed-magnitude products for one dot product and orders the operands so the larger magnitude is always on A. It drives the add/subtract select, holds the running sum in a register and presents the final sum through a valid/ready handshake. The `accumulator` adder is instantiated inside this block.

---
 rtl/neuron_pkg.sv | 23 ++
 rtl/accumulator.sv | 18 +
 rtl/neuron_acc_ctrl.sv | 104 ++++++++++
 tb/tb_neuron_acc_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron accumulator control path.
// Data width follows the project-wide DATAWIDTH define from param_def.sv.
`ifndef DATAWIDTH
`define DATAWIDTH 8
`endif

package neuron_pkg;

  localparam int unsigned W = `DATAWIDTH + 2;
  localparam logic [W-1:0] MAG_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic         sign;
    logic [W-1:0] mag;
  } sm_t;

endpackage

// File: rtl/accumulator.sv
// Magnitude adder/subtractor: o = a + b when s=0, o = a - b when s=1.
// Wraps modulo 2^W; callers detect overflow by comparing o against a.
module accumulator
  import neuron_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] o
);

  always_comb begin
    o = '0;
    if (s) o = a - b;
    else   o = a + b;
  end

endmodule

// File: rtl/neuron_acc_ctrl.sv
// Sign-magnitude sequencing for one dot product: orders operands so the larger
// magnitude drives A, tracks the running sum and hands the result downstream.
module neuron_acc_ctrl
  import neuron_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 64,
  parameter int unsigned CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [W-1:0]  in_mag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [W-1:0]  out_mag,
  output logic          out_sat
);

  state_t        state;
  sm_t           sum;
  logic [CW-1:0] cnt;
  logic          sat;

  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_s;
  logic [W-1:0]  add_o;
  logic          pre_sign;
  logic          wrap;
  sm_t           nxt;

  // Larger magnitude always on A so subtraction can never borrow.
  always_comb begin
    op_a     = sum.mag;
    op_b     = in_mag;
    op_s     = 1'b0;
    pre_sign = sum.sign;
    if (in_sign != sum.sign) begin
      op_s = 1'b1;
      if (in_mag > sum.mag) begin
        op_a     = in_mag;
        op_b     = sum.mag;
        pre_sign = in_sign;
      end
    end
  end

  accumulator u_acc (
    .a (op_a),
    .b (op_b),
    .s (op_s),
    .o (add_o)
  );

  always_comb begin
    wrap     = !op_s && (add_o < op_a);
    nxt.mag  = wrap ? MAG_MAX : add_o;
    nxt.sign = (nxt.mag == '0) ? 1'b0 : pre_sign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sum   <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sum   <= '0;
            sat   <= 1'b0;
            cnt   <= len;
            state <= (len != '0) ? ACCUM : DONE;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            sum <= nxt;
            cnt <= cnt - CW'(1);
            if (wrap) sat <= 1'b1;
            if (cnt == CW'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_sign  = sum.sign;
  assign out_mag   = sum.mag;
  assign out_sat   = sat;

endmodule

// File: tb/tb_neuron_acc_ctrl.sv
// Directed bench for neuron_acc_ctrl with hand-computed sign-magnitude results.
module tb_neuron_acc_ctrl;
  import neuron_pkg::*;

  localparam int unsigned CW = $clog2(64 + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [W-1:0]  in_mag;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [W-1:0]  out_mag;
  logic          out_sat;

  int n_cmp = 0;
  int n_err = 0;

  neuron_acc_ctrl #(.MAX_TERMS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic begin_run(input int n);
    start = 1'b1;
    len   = CW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic term(input logic sg, input int mg);
    in_valid = 1'b1;
    in_sign  = sg;
    in_mag   = W'(mg);
    chk("in_ready_accum", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic sg, input int mg, input logic st);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sign"},  32'(out_sign),  32'(sg));
    chk({tag, "_mag"},   32'(out_mag),   32'(mg));
    chk({tag, "_sat"},   32'(out_sat),   32'(st));
    chk({tag, "_noready"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_sign = 1'b0; in_mag = '0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sign",  32'(out_sign),  32'd0);
    chk("rst_out_mag",   32'(out_mag),   32'd0);
    chk("rst_out_sat",   32'(out_sat),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_ready", 32'(in_ready), 32'd0);

    // 1: back-to-back, 100 + 200 - 50 = +250
    begin_run(3);
    term(1'b0, 100);
    term(1'b0, 200);
    chk("s1_not_done", 32'(out_valid), 32'd0);
    term(1'b1, 50);
    expect_result("s1", 1'b0, 250, 1'b0);

    // 2: 30 - 100 = -70; then 5 - 5 = +0
    begin_run(2);
    term(1'b0, 30);
    term(1'b1, 100);
    expect_result("s2a", 1'b1, 70, 1'b0);
    begin_run(2);
    term(1'b0, 5);
    term(1'b1, 5);
    expect_result("s2b", 1'b0, 0, 1'b0);

    // 3: 1000 + 100 saturates; sat cleared on next run
    begin_run(2);
    term(1'b0, 1000);
    term(1'b0, 100);
    expect_result("s3a", 1'b0, 1023, 1'b1);
    begin_run(1);
    term(1'b0, 7);
    expect_result("s3b", 1'b0, 7, 1'b0);
    begin_run(3);
    term(1'b0, 1000);
    term(1'b0, 100);
    term(1'b1, 50);
    expect_result("s3c", 1'b0, 973, 1'b1);

    // 4: zero-length run and gapped input
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    expect_result("s4a", 1'b0, 0, 1'b0);
    begin_run(3);
    term(1'b0, 100);
    @(negedge clk); @(negedge clk);
    chk("s4_stall_ready", 32'(in_ready), 32'd1);
    chk("s4_stall_mag",   32'(out_mag),  32'd100);
    term(1'b0, 200);
    @(negedge clk);
    term(1'b1, 50);
    expect_result("s4b", 1'b0, 250, 1'b0);

    // 5: DONE held with out_ready low; start/in_valid ignored
    begin_run(2);
    term(1'b0, 3);
    term(1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      start = i[0]; len = CW'(5); in_valid = ~i[0]; in_sign = 1'b1; in_mag = W'(99);
      chk("s5_hold_valid", 32'(out_valid), 32'd1);
      chk("s5_hold_mag",   32'(out_mag),   32'd7);
      chk("s5_hold_ready", 32'(in_ready),  32'd0);
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
    expect_result("s5", 1'b0, 7, 1'b0);
    @(negedge clk);
    chk("s5_stay_idle", 32'(in_ready), 32'd0);

    // 6: reset mid-run, then fresh single term
    begin_run(4);
    term(1'b0, 10);
    term(1'b0, 20);
    #1 rst_n = 1'b0;
    #1;
    chk("s6_rst_ready", 32'(in_ready),  32'd0);
    chk("s6_rst_valid", 32'(out_valid), 32'd0);
    chk("s6_rst_mag",   32'(out_mag),   32'd0);
    chk("s6_rst_sign",  32'(out_sign),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    begin_run(1);
    term(1'b1, 9);
    expect_result("s6", 1'b1, 9, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
